uni_bs_acc: RTL
===============

// Module: uni_bs_acc
// PURPOSE
//  Unipolar stochastic-to-binary converter; sits directly downstream of andMUL (gMUL_uni).
//  Counts 1s on the product bitstream oC over a fixed window of 2**WIN_LOG2 qualified cycles.
//  Returns the binary estimate of P(oC=1) scaled to OWD bits, with a one-cycle valid pulse.
//  Closes the loop for multiplier accuracy sweeps: load iA/iB, start, read oValue.
// PARAMETERS
//  WIN_LOG2  8       log2 of window length in qualified cycles (window = 256 by default)
//  OWD       `INWD   output width; result = ones_count >> (WIN_LOG2-OWD) if WIN_LOG2>=OWD,
//                    else ones_count << (OWD-WIN_LOG2)
// PORTS
//  clk     in   1         clock, rising edge
//  rst_n   in   1         asynchronous reset, active low
//  iBit    in   1         stochastic bit (connect to andMUL.oC)
//  iEn     in   1         bit qualifier; iBit counted and window advanced only when 1
//  start   in   1         begin a conversion (assert with andMUL loadA/loadB)
//  oValue  out  OWD       converted binary value, held until next oValid
//  oValid  out  1         one-cycle pulse when oValue updates
//  busy    out  1         high while a window is in progress
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, oValue=0, oValid=0, busy=0, window/ones counters=0.
//  FSM: IDLE -> RUN on start=1 (counters cleared that edge); RUN -> DONE when window count
//    reaches 2**WIN_LOG2-1 with iEn=1; DONE -> IDLE next cycle (oValid=1 in DONE only).
//  Alignment: iBit first sampled the cycle AFTER start (andMUL output is valid one cycle
//    after load), so start and loadA/loadB are driven in the same cycle.
//  RUN: each cycle with iEn=1: win_cnt += 1; ones_cnt += iBit. iEn=0: both hold.
//  ones_cnt is WIN_LOG2+1 bits; all-ones window (count = 2**WIN_LOG2) saturates result
//    to {OWD{1'b1}} after scaling; no wrap-around.
//  Latency: oValid asserted exactly 2**WIN_LOG2 qualified cycles + 1 after start
//    (257 clocks with iEn tied high, default params).
//  busy=1 in RUN and DONE, 0 in IDLE. oValue updated on entry to DONE and held otherwise.
//  start while busy=1: ignored (no restart, counters unaffected).
//  start in DONE cycle: ignored; must be reissued in IDLE (except with ACC_CONT_EN).
//  Reset mid-window: conversion aborted, all state/outputs return to reset values at once.
//  X on iBit while iEn=0 must not affect counts.
// CONFIGURATION
//  ACC_CONT_EN defined: continuous mode; DONE -> RUN directly (counters cleared), so
//    windows are back-to-back with zero gap; start only needed once from IDLE;
//    busy stays 1 until reset. iBit in the DONE cycle counts as first bit of next window.
//  ACC_CONT_EN undefined: single-shot as described above; returns to IDLE after each window.
// TESTING
//  1. iBit=1, iEn=1, start pulse -> oValid at clock 257 after start, oValue=255 (saturated).
//  2. iBit=0 constant -> oValue=0, oValid single pulse, busy falls one cycle after it.
//  3. iBit alternating 1/0, iEn=1 -> oValue=128 exactly.
//  4. iBit=1, iEn toggling 1/0 -> oValid at clock 513, oValue=255; zero-iEn cycles skipped.
//  5. rst_n=0 at clock 100 of window -> oValid/busy/oValue=0 immediately; start re-accepted
//     after release, next result correct (rerun case 3 -> 128).
//  6. Chained with andMUL, iA=iB=128, load+start together -> oValue within 64+/-8;
//     start pulsed mid-window ignored; with ACC_CONT_EN, oValid every 256 clocks.

Source files
------------

// File: rtl/uni_bs_acc.sv
// Unipolar stochastic-to-binary converter: counts ones over 2**WIN_LOG2 qualified cycles.
// Optional continuous (back-to-back window) mode enabled by defining ACC_CONT_EN.
module uni_bs_acc #(
  parameter int WIN_LOG2 = 8,
  parameter int OWD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           iBit,
  input  logic           iEn,
  input  logic           start,
  output logic [OWD-1:0] oValue,
  output logic           oValid,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDE = WIN_LOG2 + OWD + 1;
  localparam int SHR  = (WIN_LOG2 >= OWD) ? (WIN_LOG2 - OWD) : 0;
  localparam int SHL  = (OWD > WIN_LOG2) ? (OWD - WIN_LOG2) : 0;
  localparam logic [WIN_LOG2-1:0] WIN_MAX = '1;

  // Scale a window ones-count to OWD bits; a full window (count = 2**WIN_LOG2) saturates.
  function automatic logic [OWD-1:0] scale_count(input logic [WIN_LOG2:0] cnt);
    logic [WIDE-1:0] wide;
    wide = {{OWD{1'b0}}, cnt};
    if (cnt[WIN_LOG2]) begin
      return {OWD{1'b1}};
    end else begin
      wide = (wide >> SHR) << SHL;
      return wide[OWD-1:0];
    end
  endfunction

  state_t                state_r;
  logic [WIN_LOG2-1:0]   win_cnt_r;
  logic [WIN_LOG2:0]     ones_cnt_r;
  logic [OWD-1:0]        value_r;
  logic                  valid_r;
  logic                  busy_r;

  // Gating by iEn keeps an unknown iBit out of the count while unqualified.
  logic                  bit_s;
  logic [WIN_LOG2:0]     ones_next_s;

  assign bit_s       = iEn & iBit;
  assign ones_next_s = ones_cnt_r + (WIN_LOG2 + 1)'(bit_s);

  // Conversion FSM with counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      win_cnt_r  <= '0;
      ones_cnt_r <= '0;
      value_r    <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_RUN;
            win_cnt_r  <= '0;
            ones_cnt_r <= '0;
            busy_r     <= 1'b1;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ST_RUN: begin
          busy_r <= 1'b1;
          if (iEn) begin
            win_cnt_r  <= win_cnt_r + WIN_LOG2'(1);
            ones_cnt_r <= ones_next_s;
            if (win_cnt_r == WIN_MAX) begin
              state_r <= ST_DONE;
              value_r <= scale_count(ones_next_s);
              valid_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
`ifdef ACC_CONT_EN
          // The DONE-cycle bit opens the next window, so windows abut with no gap.
          state_r    <= ST_RUN;
          win_cnt_r  <= WIN_LOG2'(iEn);
          ones_cnt_r <= (WIN_LOG2 + 1)'(bit_s);
          busy_r     <= 1'b1;
`else
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oValue = value_r;
  assign oValid = valid_r;
  assign busy   = busy_r;

endmodule
